// File: rtl/display_update_sched.sv
// Display update scheduler: arbitrates config vs. time writes to the MAX7219 wrapper.
// Optional periodic config refresh is built when SCHED_CFG_REFRESH_EN is defined.
//
// state | meaning
// IDLE  | choose the next transaction (config beats time); snapshot taken here
// ISSUE | present o_stb until the wrapper is not busy
// WAIT  | transfer accepted, hold type and snapshot until i_ack
module display_update_sched #(
    parameter int TIMEOUT_CYCLES    = 4096,
    parameter int CFG_REFRESH_TICKS = 60
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic [4:0] i_hours,
    input  logic [5:0] i_minutes,
    input  logic [5:0] i_seconds,
    input  logic [5:0] i_dp,
    input  logic       i_tick,
    input  logic       i_cfg_req,
    input  logic       i_force,
    output logic       o_stb,
    output logic       o_write_config,
    input  logic       i_busy,
    input  logic       i_ack,
    output logic [4:0] o_hours,
    output logic [5:0] o_minutes,
    output logic [5:0] o_seconds,
    output logic [5:0] o_dp,
    output logic       o_init_done,
    output logic       o_timeout
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t      state, state_nxt;
    logic        cfg_pending, time_pending, cfg_acked;
    logic [15:0] wd_cnt;
    logic        wd_fire, xfer, sel_cfg, sel_time, refresh_wrap;
    logic        cfg_set, time_set;
    logic [22:0] live, snap;

    assign live = {i_hours, i_minutes, i_seconds, i_dp};
    assign snap = {o_hours, o_minutes, o_seconds, o_dp};

    assign wd_fire  = (state != IDLE) && (wd_cnt == 16'(TIMEOUT_CYCLES - 1));
    assign cfg_set  = i_cfg_req | wd_fire | refresh_wrap;
    assign time_set = i_force | wd_fire | ((state == IDLE) && (live != snap));

    always_comb begin
        state_nxt = state;
        o_stb     = 1'b0;
        xfer      = 1'b0;
        sel_cfg   = 1'b0;
        sel_time  = 1'b0;
        case (state)
            IDLE: begin
                if (cfg_pending) begin
                    sel_cfg   = 1'b1;
                    state_nxt = ISSUE;
                end else if (time_pending) begin
                    sel_time  = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (!i_busy) begin
                    o_stb     = 1'b1;
                    xfer      = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (i_ack) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // A firing watchdog abandons the transaction, so no strobe escapes that cycle.
        if (wd_fire) begin
            state_nxt = IDLE;
            o_stb     = 1'b0;
            xfer      = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state          <= IDLE;
            cfg_pending    <= 1'b1;
            time_pending   <= 1'b1;
            cfg_acked      <= 1'b0;
            wd_cnt         <= '0;
            o_write_config <= 1'b0;
            o_hours        <= '0;
            o_minutes      <= '0;
            o_seconds      <= '0;
            o_dp           <= '0;
            o_init_done    <= 1'b0;
            o_timeout      <= 1'b0;
        end else begin
            state     <= state_nxt;
            o_timeout <= wd_fire;
            wd_cnt    <= ((state == IDLE) || (state_nxt == IDLE)) ? 16'd0 : wd_cnt + 16'd1;

            if (sel_cfg) o_write_config <= 1'b1;
            if (sel_time) begin
                o_write_config                        <= 1'b0;
                {o_hours, o_minutes, o_seconds, o_dp} <= live;
            end

            cfg_pending  <= cfg_set  | (cfg_pending  & ~(xfer &  o_write_config));
            time_pending <= time_set | (time_pending & ~(xfer & ~o_write_config));

            if ((state == WAIT) && i_ack && !wd_fire) begin
                if (o_write_config)  cfg_acked   <= 1'b1;
                else if (cfg_acked)  o_init_done <= 1'b1;
            end
        end
    end

`ifdef SCHED_CFG_REFRESH_EN
    logic [7:0] refresh_cnt;

    assign refresh_wrap = i_tick && (refresh_cnt == 8'(CFG_REFRESH_TICKS - 1));

    always_ff @(posedge i_clk) begin
        if (!i_reset_n)  refresh_cnt <= '0;
        else if (i_tick) refresh_cnt <= refresh_wrap ? 8'd0 : refresh_cnt + 8'd1;
    end
`else
    logic [8:0] unused_refresh;

    assign unused_refresh = {i_tick, 8'(CFG_REFRESH_TICKS)};
    assign refresh_wrap   = 1'b0;
`endif

endmodule

// File: tb/tb_display_update_sched.sv
// Scoreboard bench for display_update_sched: stimulus pushes expected transfers,
// a monitor pops and checks each accepted strobe and re-checks the snapshot at ack.
`timescale 1ns/1ps
module tb_display_update_sched;

    localparam int TO    = 48;
    localparam int TICKS = 3;

    typedef struct packed {
        logic       wc;
        logic [4:0] h;
        logic [5:0] m;
        logic [5:0] s;
        logic [5:0] d;
    } txn_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] i_hours;
    logic [5:0] i_minutes, i_seconds, i_dp;
    logic       i_tick, i_cfg_req, i_force, i_busy, i_ack;
    logic       o_stb, o_write_config, o_init_done, o_timeout;
    logic [4:0] o_hours;
    logic [5:0] o_minutes, o_seconds, o_dp;

    int   tests = 0;
    int   fails = 0;
    txn_t exp_q[$];
    txn_t cur;
    logic outstanding = 1'b0;
    logic no_ack      = 1'b0;
    logic exp_to      = 1'b0;
    int   ack_delay   = 20;
    int   xfers       = 0;
    int   cfg_xfers   = 0;

    always #5 clk = ~clk;

    display_update_sched #(.TIMEOUT_CYCLES(TO), .CFG_REFRESH_TICKS(TICKS)) dut (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_hours(i_hours), .i_minutes(i_minutes), .i_seconds(i_seconds), .i_dp(i_dp),
        .i_tick(i_tick), .i_cfg_req(i_cfg_req), .i_force(i_force),
        .o_stb(o_stb), .o_write_config(o_write_config),
        .i_busy(i_busy), .i_ack(i_ack),
        .o_hours(o_hours), .o_minutes(o_minutes), .o_seconds(o_seconds), .o_dp(o_dp),
        .o_init_done(o_init_done), .o_timeout(o_timeout)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_txn(input string tag, input txn_t e);
        chk({tag, "_type"}, 32'(o_write_config), 32'(e.wc));
        if (!e.wc)
            chk({tag, "_snapshot"}, 32'({o_hours, o_minutes, o_seconds, o_dp}),
                32'({e.h, e.m, e.s, e.d}));
    endtask

    task automatic push_cfg();
        txn_t t;
        t    = '0;
        t.wc = 1'b1;
        exp_q.push_back(t);
    endtask

    task automatic push_time(input logic [4:0] h, input logic [5:0] m,
                             input logic [5:0] s, input logic [5:0] d);
        txn_t t;
        t = '{wc: 1'b0, h: h, m: m, s: s, d: d};
        exp_q.push_back(t);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int budget);
        int i;
        i = 0;
        while ((exp_q.size() != 0 || outstanding) && i < budget) begin
            cyc(1);
            i++;
        end
        chk("drain_in_budget", 32'(i < budget), 32'd1);
        cyc(4);
    endtask

    // Monitor: every accepted strobe must match the head of the queue.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (o_timeout) begin
                    chk("timeout_expected", 32'(exp_to), 32'd1);
                    outstanding = 1'b0;
                end
                if (o_stb && !i_busy) begin
                    if (exp_q.size() == 0) begin
                        chk("stb_expected", 32'(exp_q.size()), 32'd1);
                    end else begin
                        cur = exp_q.pop_front();
                        chk_txn("xfer", cur);
                    end
                    outstanding = 1'b1;
                    xfers++;
                    if (o_write_config) cfg_xfers++;
                end
                if (i_ack && outstanding) begin
                    chk_txn("hold_at_ack", cur);
                    outstanding = 1'b0;
                end
            end
        end
    end

    // Wrapper model: acks ack_delay cycles after an accepted strobe.
    initial begin
        i_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && o_stb && !i_busy && !no_ack) begin
                repeat (ack_delay) @(posedge clk);
                #1 i_ack = 1'b1;
                @(posedge clk);
                #1 i_ack = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_time_limit: got expired, expected finish");
        $fatal(1, "time limit");
    end

    initial begin
        int   x0, c0, n, exp_ref, rcnt;
        logic found;
        rst_n = 1'b0; i_hours = '0; i_minutes = '0; i_seconds = '0; i_dp = '0;
        i_tick = 1'b0; i_cfg_req = 1'b0; i_force = 1'b0; i_busy = 1'b0;
        exp_ref = 0; rcnt = 0;

        // Reset state, then config write followed by time 0:00:00.
        cyc(3);
        @(negedge clk);
        chk("rst_stb", 32'(o_stb), 32'd0);
        chk("rst_wc", 32'(o_write_config), 32'd0);
        chk("rst_init_done", 32'(o_init_done), 32'd0);
        chk("rst_timeout", 32'(o_timeout), 32'd0);
        chk("rst_snapshot", 32'({o_hours, o_minutes, o_seconds, o_dp}), 32'd0);
        push_cfg();
        push_time(5'd0, 6'd0, 6'd0, 6'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("init_done_early", 32'(o_init_done), 32'd0);
        wait_done(200);
        chk("init_done_after_boot", 32'(o_init_done), 32'd1);

        // Seconds 05 -> 06: strobe two cycles later, snapshot held while 07 arrives.
        push_time(5'd0, 6'd0, 6'd5, 6'd0);
        i_seconds = 6'd5;
        wait_done(200);
        push_time(5'd0, 6'd0, 6'd6, 6'd0);
        i_seconds = 6'd6;
        @(posedge clk);
        @(negedge clk);
        chk("latency_cycle1_stb", 32'(o_stb), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("latency_cycle2_stb", 32'(o_stb), 32'd1);
        cyc(5);
        push_time(5'd0, 6'd0, 6'd7, 6'd0);
        i_seconds = 6'd7;
        wait_done(300);

        // Simultaneous config request and force: config first, then time.
        push_cfg();
        push_time(5'd0, 6'd0, 6'd7, 6'd0);
        i_cfg_req = 1'b1; i_force = 1'b1;
        cyc(1);
        i_cfg_req = 1'b0; i_force = 1'b0;
        wait_done(300);
        chk("init_done_kept", 32'(o_init_done), 32'd1);

        // Wrapper busy for 10 cycles: no strobe until it drops, then exactly one.
        i_busy = 1'b1;
        push_time(5'd12, 6'd34, 6'd7, 6'h04);
        i_hours = 5'd12; i_minutes = 6'd34; i_dp = 6'h04;
        x0 = xfers;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("busy_hold_stb", 32'(o_stb), 32'd0);
        end
        @(posedge clk);
        #1 i_busy = 1'b0;
        wait_done(300);
        chk("busy_single_stb", 32'(xfers - x0), 32'd1);

        // Wrapper never acks: watchdog pulse TO cycles after the strobe, then recovery.
        no_ack = 1'b1; exp_to = 1'b1;
        push_time(5'd12, 6'd34, 6'd7, 6'h04);
        i_force = 1'b1;
        cyc(1);
        i_force = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (o_stb) found = 1'b1;
        end
        chk("wd_stb_seen", 32'(found), 32'd1);
        found = 1'b0;
        n = 0;
        for (int i = 0; i < 4 * TO && !found; i++) begin
            @(negedge clk);
            n++;
            if (o_timeout) found = 1'b1;
        end
        chk("wd_timeout_seen", 32'(found), 32'd1);
        chk("wd_timeout_latency", 32'(n), 32'(TO));
        chk("wd_init_done_kept", 32'(o_init_done), 32'd1);
        push_cfg();
        push_time(5'd12, 6'd34, 6'd7, 6'h04);
        #1 no_ack = 1'b0; exp_to = 1'b0;
        @(negedge clk);
        chk("wd_pulse_width", 32'(o_timeout), 32'd0);
        @(posedge clk);
        #1;
        wait_done(300);

        // Seven ticks: with refresh built and TICKS=3, two config rewrites; otherwise none.
        c0 = cfg_xfers;
        for (int k = 0; k < 7; k++) begin
            i_tick = 1'b1;
`ifdef SCHED_CFG_REFRESH_EN
            if (rcnt == TICKS - 1) begin
                rcnt = 0;
                push_cfg();
                exp_ref++;
            end else begin
                rcnt++;
            end
`endif
            cyc(1);
            i_tick = 1'b0;
            cyc(40);
        end
        wait_done(300);
        chk("refresh_cfg_writes", 32'(cfg_xfers - c0), 32'(exp_ref));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
